// File: rtl/apb3_regbank_pkg.sv
// apb3_regbank_pkg: shared register offsets and FSM state encoding for the
// APB3 register bank.
package apb3_regbank_pkg;

  // Byte offsets of the fixed registers; scratch words follow REG_SCRATCH0.
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_IRQ_EN   = 8'h08;
  localparam logic [7:0] REG_IRQ_PEND = 8'h0C;
  localparam logic [7:0] REG_SCRATCH0 = 8'h10;

  // Slave-side view of the APB transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb3_regbank_if.sv
// apb3_regbank_if: APB3 bus bundle between the bridge (master) and the
// register bank (slave).
interface apb3_regbank_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERROR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERROR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERROR
  );
endinterface

// File: rtl/apb3_irq_ctrl.sv
// apb3_irq_ctrl: rising-edge interrupt capture with W1C pending bits, an
// enable mask and a registered interrupt output. Only instantiated by
// apb3_regbank when APB3_REGBANK_IRQ_EN is defined.
module apb3_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               en_we_i,
  input  logic               pend_w1c_i,
  input  logic [NUM_IRQ-1:0] wdata_i,
  output logic [NUM_IRQ-1:0] irq_en_o,
  output logic [NUM_IRQ-1:0] irq_pend_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] irq_en_q;
  logic [NUM_IRQ-1:0] irq_pend_q;
  logic [NUM_IRQ-1:0] irq_pend_d;
  logic               irq_q;

  // Next pending: clear written ones first, then OR in new edges so a
  // coincident edge always survives the clear.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (pend_w1c_i) irq_pend_d = irq_pend_d & ~wdata_i;
    irq_pend_d = irq_pend_d | (irq_src_i & ~irq_prev_q);
  end

  // Edge-detect history, enable mask, pending bits and the registered interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_prev_q <= '0;
      irq_en_q   <= '0;
      irq_pend_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq_src_i;
      if (en_we_i) irq_en_q <= wdata_i;
      irq_pend_q <= irq_pend_d;
      irq_q      <= |(irq_pend_q & irq_en_q);
    end
  end

  assign irq_en_o   = irq_en_q;
  assign irq_pend_o = irq_pend_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/apb3_regbank.sv
// apb3_regbank: APB3 register-bank slave. CTRL drives ctrl_out, STATUS
// samples status_in, NUM_REG scratch words, optional interrupt block.
// Define APB3_REGBANK_IRQ_EN to build IRQ_EN/IRQ_PEND and edge detection;
// otherwise those offsets read 0, ignore writes and apb3Interrupt is 0.
// ADDR_WIDTH must be greater than 8.
module apb3_regbank
  import apb3_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REG     = 4,
  parameter int NUM_IRQ     = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  apb3_regbank_if.slave         apb,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  input  logic [DATA_WIDTH-1:0] status_in,
  input  logic [NUM_IRQ-1:0]    irq_src,
  output logic                  apb3Interrupt
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
  localparam logic [5:0] SCR_IDX  = REG_SCRATCH0[7:2];

  apb_state_e            state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] scratch_rd [NUM_REG];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] irq_en_ext;
  logic [DATA_WIDTH-1:0] irq_pend_ext;

  logic [5:0] widx;
  logic [7:0] woff;
  logic       oor;
  logic       ready;
  logic       wr_commit;
  logic       rd_sample;
  logic       unused_addr;

  // Address decode: word index from PADDR[7:2]; byte lanes are ignored.
  assign widx        = apb.PADDR[7:2];
  assign woff        = {widx, 2'b00};
  assign oor         = (apb.PADDR[ADDR_WIDTH-1:8] != '0) ||
                       ({1'b0, widx} >= 7'(4 + NUM_REG));
  assign unused_addr = ^apb.PADDR[1:0];

  assign ready     = (state_q == ACCESS) && (cnt_q == WAIT_CNT);
  assign wr_commit = ready && apb.PWRITE && !oor;
  assign rd_sample = (state_q == SETUP) && apb.PENABLE && !apb.PWRITE;

  // Transfer FSM with wait-state counter; the counter restarts in SETUP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb.PSEL && !apb.PENABLE) state_q <= SETUP;
        end
        SETUP: begin
          cnt_q   <= '0;
          state_q <= apb.PENABLE ? ACCESS : IDLE;
        end
        ACCESS: begin
          if (ready) state_q <= (apb.PSEL && !apb.PENABLE) ? SETUP : IDLE;
          else       cnt_q   <= cnt_q + 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Scratch words, one storage register per index.
  for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_scratch
    logic [DATA_WIDTH-1:0] word_q;

    // Capture a committed write addressed to this scratch word.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                     word_q <= '0;
      else if (wr_commit && widx == 6'(SCR_IDX + gi)) word_q <= apb.PWDATA;
    end

    assign scratch_rd[gi] = word_q;
  end

`ifdef APB3_REGBANK_IRQ_EN
  logic [NUM_IRQ-1:0] irq_en_w;
  logic [NUM_IRQ-1:0] irq_pend_w;
  logic               irq_en_we;
  logic               irq_pend_w1c;

  assign irq_en_we    = wr_commit && (woff == REG_IRQ_EN);
  assign irq_pend_w1c = wr_commit && (woff == REG_IRQ_PEND);

  apb3_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_ctrl (
    .clk        (clk),
    .resetn     (resetn),
    .irq_src_i  (irq_src),
    .en_we_i    (irq_en_we),
    .pend_w1c_i (irq_pend_w1c),
    .wdata_i    (apb.PWDATA[NUM_IRQ-1:0]),
    .irq_en_o   (irq_en_w),
    .irq_pend_o (irq_pend_w),
    .irq_o      (apb3Interrupt)
  );

  // Zero-extend the interrupt registers to bus width for readback.
  always_comb begin
    irq_en_ext                  = '0;
    irq_pend_ext                = '0;
    irq_en_ext[NUM_IRQ-1:0]     = irq_en_w;
    irq_pend_ext[NUM_IRQ-1:0]   = irq_pend_w;
  end
`else
  logic unused_irq;

  assign unused_irq    = ^irq_src;
  assign irq_en_ext    = '0;
  assign irq_pend_ext  = '0;
  assign apb3Interrupt = 1'b0;
`endif

  // Read multiplexer over the register map (out-of-range handled at capture).
  always_comb begin
    rd_mux = '0;
    case (woff)
      REG_CTRL:     rd_mux = ctrl_q;
      REG_STATUS:   rd_mux = status_q;
      REG_IRQ_EN:   rd_mux = irq_en_ext;
      REG_IRQ_PEND: rd_mux = irq_pend_ext;
      default: begin
        for (int i = 0; i < NUM_REG; i++) begin
          if (widx == 6'(SCR_IDX + i)) rd_mux = scratch_rd[i];
        end
      end
    endcase
  end

  // CTRL writes, STATUS sampling, and PRDATA capture at the start of a read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q   <= '0;
      status_q <= '0;
      rdata_q  <= '0;
    end else begin
      status_q <= status_in;
      if (wr_commit && woff == REG_CTRL) ctrl_q  <= apb.PWDATA;
      if (rd_sample)                     rdata_q <= oor ? '0 : rd_mux;
    end
  end

  assign apb.PREADY    = ready;
  assign apb.PSLVERROR = ready && oor;
  assign apb.PRDATA    = rdata_q;
  assign ctrl_out      = ctrl_q;

endmodule
